// File: rtl/icache_direct_pkg.sv
// Shared constants, state encodings and default geometry for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;
    localparam logic [31:0] Null32 = 32'h0000_0000;

    localparam int unsigned DefaultIndexW = 8;

    localparam logic ICACHE_IDLE = 1'b0;
    localparam logic ICACHE_MISS = 1'b1;

    typedef enum logic {
        StIdle = ICACHE_IDLE,
        StMiss = ICACHE_MISS
    } icache_state_e;

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag/data storage for icache_direct: combinational read port, synchronous write port,
// valid bits cleared on rst.
module icache_tag_array
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W = DefaultIndexW,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] widx_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [31:0]        wdata_i,
    input  logic [INDEX_W-1:0] ridx_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [31:0]        rdata_o
);

    localparam int unsigned Lines = 2 ** INDEX_W;

    logic [Lines-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= True;
        end
    end

    // Only the valid bits need clearing; tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache with a single outstanding miss.
// Define ICACHE_PERF_EN to add the hit_cnt/miss_cnt performance counters.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W = DefaultIndexW,
    parameter int unsigned ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic        val_in_flag_IF,
    input  logic [31:0] addr_IF,
    output logic        val_out_flag_IF,
    output logic [31:0] val_out_IF,
    output logic        val_out_flag_MC,
    output logic [31:0] addr_MC,
    input  logic        val_in_flag_MC,
    input  logic [31:0] val_in_MC
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

    icache_state_e      state_q, state_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag, rd_tag;
    logic               rd_valid;
    logic [31:0]        rd_data;
    logic               hit, start_miss, fill, abort;
    logic               unused_addr_lsb;

    assign req_idx  = addr_IF[INDEX_W+1:2];
    assign req_tag  = addr_IF[ADDR_W-1:INDEX_W+2];
    assign fill_idx = miss_addr_q[INDEX_W+1:2];
    assign fill_tag = miss_addr_q[ADDR_W-1:INDEX_W+2];
    assign unused_addr_lsb = ^addr_IF[1:0];

    icache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .we_i     (fill),
        .widx_i   (fill_idx),
        .wtag_i   (fill_tag),
        .wdata_i  (val_in_MC),
        .ridx_i   (req_idx),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    always_comb begin
        hit = val_in_flag_IF && rd_valid && (rd_tag == req_tag) && (state_q == StIdle)
              && !jp_wrong;
        val_out_flag_IF = hit;
        val_out_IF      = hit ? rd_data : Null32;
        // Dropped in the completion cycle so MemCtrl never restarts a fetch.
        val_out_flag_MC = (state_q == StMiss) && !val_in_flag_MC && !jp_wrong;
        addr_MC         = (state_q == StMiss) ? miss_addr_q : Null32;

        start_miss = rdy && !rst && (state_q == StIdle) && val_in_flag_IF && !hit && !jp_wrong;
        fill       = rdy && !rst && (state_q == StMiss) && val_in_flag_MC && !jp_wrong;
        abort      = rdy && (state_q == StMiss) && jp_wrong;
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        if (start_miss) begin
            state_d     = StMiss;
            miss_addr_d = {addr_IF[31:2], 2'b00};
        end else if (fill || abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            miss_addr_q <= Null32;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= Null32;
            miss_cnt <= Null32;
        end else begin
            if (rdy && hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_miss) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: driver acts as IF and MemCtrl, monitor checks every hit.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst, rdy, jp_wrong, val_in_flag_IF, val_in_flag_MC;
    logic [31:0] addr_IF, val_in_MC;
    logic        val_out_flag_IF, val_out_flag_MC;
    logic [31:0] val_out_IF, addr_MC;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: which line address each set holds, and the word it holds.
    bit          m_valid [256];
    logic [15:0] m_line  [256];
    logic [31:0] m_data  [256];
    int          m_hits, m_misses;

    icache_direct u_dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .jp_wrong        (jp_wrong),
        .val_in_flag_IF  (val_in_flag_IF),
        .addr_IF         (addr_IF),
        .val_out_flag_IF (val_out_flag_IF),
        .val_out_IF      (val_out_IF),
        .val_out_flag_MC (val_out_flag_MC),
        .addr_MC         (addr_MC),
        .val_in_flag_MC  (val_in_flag_MC),
        .val_in_MC       (val_in_MC)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[17:0] == 18'h4) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[9:2]] && (m_line[a[9:2]] == a[17:2]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Monitor: every hit must match the next scoreboard entry; no hit means a zero word.
    always @(negedge clk) begin
        if (!rst) begin
            if (val_out_flag_IF) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: got hit data %h expected no hit at %0t",
                             val_out_IF, $time);
                end else begin
                    check("hit_data", val_out_IF, exp_q.pop_front());
                end
            end else begin
                check("nohit_zero", val_out_IF, 32'h0);
            end
        end
    end

    // One IF request; on a miss the bench plays MemCtrl with the given latency, optional
    // rdy stall, and optional jp_wrong on the last cycle (race = word returned that cycle too).
    task automatic fetch(input logic [31:0] a, input int lat, input bit abort, input bit race,
                         input int stall_at, input int stall_n, input bit wiggle);
        logic [31:0] word;
        int          n;
        bit          last;
        word = mem_word(a);
        n    = lat + stall_n;
        @(posedge clk); #1;
        val_in_flag_IF = 1'b1;
        addr_IF        = a;
        rdy            = 1'b1;
        if (model_hit(a)) begin
            exp_q.push_back(m_data[a[9:2]]);
            m_hits++;
            @(negedge clk);
            check("hit_no_mc_req", 32'(val_out_flag_MC), 32'h0);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            check("idle_no_mc_req", 32'(val_out_flag_MC), 32'h0);
            m_misses++;
            for (int c = 1; c <= n; c++) begin
                @(posedge clk); #1;
                rdy  = !(stall_n > 0 && c >= stall_at && c < stall_at + stall_n);
                last = (c == n);
                addr_IF = (wiggle && !last && $urandom_range(0, 2) == 0) ? ($urandom & ~32'h3) : a;
                if (last) begin
                    jp_wrong       = abort;
                    val_in_flag_MC = !abort || race;
                    val_in_MC      = word;
                end
                @(negedge clk);
                check("mc_req", 32'(val_out_flag_MC), 32'(!last));
                check("mc_addr", addr_MC, {a[31:2], 2'b00});
            end
            @(posedge clk); #1;
            jp_wrong       = 1'b0;
            val_in_flag_MC = 1'b0;
            val_in_MC      = 32'h0;
            addr_IF        = a;
            if (!abort) begin
                m_valid[a[9:2]] = 1'b1;
                m_line[a[9:2]]  = a[17:2];
                m_data[a[9:2]]  = word;
                exp_q.push_back(word);
                m_hits++;
                @(negedge clk);
                check("fill_no_mc_req", 32'(val_out_flag_MC), 32'h0);
                @(posedge clk); #1;
            end
        end
        val_in_flag_IF = 1'b0;
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        @(posedge clk); #1;
        val_in_flag_IF = 1'b1;
        addr_IF        = a;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_mc_req", 32'(val_out_flag_MC), 32'h1);
        @(posedge clk); #1;
        rst            = 1'b1;
        val_in_flag_IF = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_mc_req", 32'(val_out_flag_MC), 32'h0);
        check("rst_mc_addr", addr_MC, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          lat, st_at, st_n;
        bit          ab, rc;
        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; val_in_flag_IF = 1'b0; val_in_flag_MC = 1'b0;
        addr_IF = 32'h0; val_in_MC = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_flag_IF", 32'(val_out_flag_IF), 32'h0);
        check("rst_val_IF", val_out_IF, 32'h0);
        check("rst_flag_MC", 32'(val_out_flag_MC), 32'h0);
        check("rst_addr_MC", addr_MC, 32'h0);

        fetch(32'h0000_0004, 4, 0, 0, 0, 0, 0);  // cold miss
        fetch(32'h0000_0004, 1, 0, 0, 0, 0, 0);  // repeat hit
        fetch(32'h0000_0404, 3, 0, 0, 0, 0, 0);  // conflict eviction
        fetch(32'h0000_0004, 2, 0, 0, 0, 0, 0);
        fetch(32'h0000_0010, 2, 1, 0, 0, 0, 0);  // flush on 2nd miss cycle
        fetch(32'h0000_0010, 3, 1, 1, 0, 0, 0);  // abort racing the return
        fetch(32'h0000_0010, 2, 0, 0, 0, 0, 0);  // still cold, fills now
        fetch(32'h0000_0010, 1, 0, 0, 0, 0, 0);
        fetch(32'h0000_0020, 4, 0, 0, 2, 3, 0);  // rdy stall mid-miss
        fetch(32'h0004_0020, 1, 0, 0, 0, 0, 0);  // bits above ADDR_W alias
        reset_mid_miss(32'h0000_0030);
        fetch(32'h0000_0004, 2, 0, 0, 0, 0, 0);  // cleared by reset

        for (int k = 0; k < 250; k++) begin
            a        = 32'h0;
            a[9:2]   = 8'($urandom_range(0, 15));
            a[17:10] = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[31:18] = 14'($urandom);
            lat   = $urandom_range(1, 5);
            ab    = ($urandom_range(0, 9) == 0);
            rc    = ab && ($urandom_range(0, 1) == 1);
            st_at = 0;
            st_n  = 0;
            if (!ab && lat >= 2 && $urandom_range(0, 5) == 0) begin
                st_at = $urandom_range(1, lat - 1);
                st_n  = $urandom_range(1, 3);
            end
            fetch(a, lat, ab, rc, st_at, st_n, 1'b1);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
`ifdef ICACHE_PERF_EN
        check("hit_cnt", hit_cnt, 32'(m_hits));
        check("miss_cnt", miss_cnt, 32'(m_misses));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
